seq_detector: RTL
=================

# seq_detector

Parametrised serial pattern detector with a selectable Mealy or Moore output and a saturating match counter. It samples the one-bit input X each rising clock edge and flags when the most recent LEN samples equal PATTERN. Overlapping and non-overlapping detection are both supported, selected by parameter. It generalises the team's fixed Mealy/Moore FSM exercise blocks into one configurable unit for serial-link framing and lab sequence tasks.

## Interface
- LEN, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: LEN-bit target. The MSB is the oldest bit and the LSB is the newest.
- OVERLAP, 1: 1 means a match's trailing bits may start the next match; 0 means history restarts after each match.
- MOORE, 0: 0 means Q is combinational (Mealy); 1 means Q is registered (Moore).
- CNT_W, 8: width of the match counter.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- X  in  1  serial data bit, sampled on the rising clk edge.
- en  in  1  sample enable; when low, X is ignored and all state holds.
- clr  in  1  synchronous clear of history and counter; priority over everything except reset.
- Q  out  1  match flag.
- count  out  CNT_W  number of accepted matches, saturating.
- sat  out  1  high while count equals 2^CNT_W-1.

## Operation
- **State**
  - sh: LEN-1 history bits, newest in bit 0.
  - fill: 0..LEN-1, the number of valid history bits; saturates at LEN-1.
  - count register.
  - qreg: used only when MOORE=1.
- **Match term:** match_now = en && !clr && fill==LEN-1 && {sh, X}==PATTERN.
- **Rising edge, clr=1:** sh←0, fill←0, count←0, qreg←0.
- **Rising edge, en=1, clr=0:**
  - sh←{sh[LEN-3:0], X}.
  - If match_now and OVERLAP=0: fill←0.
  - Otherwise: fill←min(fill+1, LEN-1).
  - If match_now and count is not all-ones: count←count+1. Once all-ones, count holds.
- **Rising edge, en=0, clr=0:** sh, fill and count hold.
- **qreg:** qreg←match_now on every edge, so en=0 gives qreg←0.
- **Output Q:**
  - MOORE=0: Q = match_now, purely combinational from X, en, clr and state.
  - MOORE=1: Q = qreg.
- **sat:** sat = (count == all-ones), combinational.
- **No-match guarantees:**
  - No match is possible until LEN samples have been accepted since reset, clr, or a non-overlap match.
  - A pattern equal to the history before fill reaches LEN-1 does not fire. This applies to power-up zeros too.
- **Reset:** asserting reset at any time, including mid-pattern, immediately forces sh=0, fill=0, count=0, qreg=0, hence Q=0 and sat=0. The first sample after release starts a fresh history.

## Timing
- **Input sampling:** X, en and clr are sampled on the rising edge. The bench drives them on the falling edge.
- **Mealy (MOORE=0):**
  - Q rises in the same cycle the final pattern bit is presented, before the edge that accepts it.
  - Q is valid 1 ps after the preceding falling-edge change.
  - Q at the edge where the bit is accepted is the match for that bit; after the edge it reflects the next X.
- **Moore (MOORE=1):** Q rises 1 cycle later than the Mealy Q (just after the accepting edge) and stays high exactly 1 cycle per match.
- **count:** updates on the accepting edge and is visible after that edge in both modes.
- **Latency:** MOORE=1 Q and count share the same cycle.
- **Back-to-back matches:**
  - OVERLAP=1 with 1011: the minimum spacing is 3 samples.
  - OVERLAP=0: the minimum spacing is LEN samples.
- **Simultaneous clr and match:** clr wins. No count increment, Q low in both modes.
- **Reset deassertion:** synchronous release is not required. The first edge after reset goes high samples normally.

## Test plan
1. **Mealy overlapping detection.** LEN=4, PATTERN=1011, OVERLAP=1, MOORE=0, en=1, X stream 1,0,1,1,0,1,1 → Q high while the 4th and 7th bits are presented and low otherwise; count=2 after the 7th edge.
2. **Non-overlapping detection.** Same stream with OVERLAP=0 → Q high only on the 4th bit; stream 1,0,1,1,0,1,1,0,1,1 gives hits on bits 4 and 10 (bits 5–8 = 0,1,1,0, no match); count=2.
3. **Mealy/Moore equivalence.** Instantiate a MOORE=0 and a MOORE=1 copy on the same stimulus → the Moore Q equals the Mealy Q delayed exactly one cycle over a 32-bit pseudo-random stream; the count values are identical every cycle.
4. **Enable hold.** Stream 1,0,1, then en=0 for 3 cycles with X toggling, then en=1 with X=1 → Q stays low while en=0 and a match fires on the resumed 1; count=1.
5. **Reset and clear mid-pattern.** Pull reset low after 1,0,1 (count=0), release, then send 1 → no match, count=0. Repeat using clr in the cycle where the final 1 completes 1011 → Q low, count=0.
6. **Counter saturation.** CNT_W=2, OVERLAP=1, repeat 1011 five times → count sequence 1,2,3,3,3; sat goes high after the 3rd match and stays high; Q still pulses on every match.

Source files
------------

// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//   Serial pattern detector. Each accepted sample of X is appended to a short
//   history; a match is flagged when the last LEN samples equal PATTERN.
//   Output Q is either the combinational match term (Mealy) or a registered
//   copy of it (Moore). Accepted matches are counted in a saturating counter.
//
// Parameters
//   LEN      pattern length in bits (2..16)
//   PATTERN  LEN-bit target, MSB = oldest sample, LSB = newest sample
//   OVERLAP  1: trailing bits of a match may start the next one
//            0: history restarts after every match
//   MOORE    0: Q combinational (Mealy), 1: Q registered (Moore)
//   CNT_W    width of the match counter
//
// Ports
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous, active-low reset
//   X      in   1      serial data bit
//   en     in   1      sample enable; low holds all state
//   clr    in   1      synchronous clear of history, fill and counter
//   Q      out  1      match flag
//   count  out  CNT_W  saturating count of accepted matches
//   sat    out  1      high while count is all-ones
// ---------------------------------------------------------------------------
module seq_detector #(
    parameter int unsigned      LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b0,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             X,
    input  logic             en,
    input  logic             clr,
    output logic             Q,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    // fill counts 0..LEN-1, so $clog2(LEN) bits always suffice for LEN >= 2
    localparam int unsigned       FILL_W   = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [LEN-2:0]    sh_r;       // previous LEN-1 samples, newest in bit 0
    logic [FILL_W-1:0] fill_r;     // number of valid bits held in sh_r
    logic [CNT_W-1:0]  count_r;
    logic              qreg_r;

    logic [LEN-1:0]    window_s;   // history plus the sample being presented
    logic              fill_full_s;
    logic              cnt_full_s;
    logic              match_now_s;
    logic              q_s;

    assign window_s    = {sh_r, X};
    assign fill_full_s = (fill_r == FILL_MAX);
    assign cnt_full_s  = (count_r == CNT_MAX);

    // A match needs a fully valid history so stale or power-up zeros never fire
    assign match_now_s = en & ~clr & fill_full_s & (window_s == PATTERN);

    // History, fill level, match counter and Moore flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_r    <= '0;
            fill_r  <= '0;
            count_r <= '0;
            qreg_r  <= 1'b0;
        end else if (clr) begin
            sh_r    <= '0;
            fill_r  <= '0;
            count_r <= '0;
            qreg_r  <= 1'b0;
        end else begin
            // match_now_s is already low when en is low
            qreg_r <= match_now_s;
            if (en) begin
                sh_r <= window_s[LEN-2:0];
                if (match_now_s && !OVERLAP) begin
                    fill_r <= '0;
                end else if (!fill_full_s) begin
                    fill_r <= fill_r + 1'b1;
                end else begin
                    fill_r <= fill_r;
                end
                if (match_now_s && !cnt_full_s) begin
                    count_r <= count_r + 1'b1;
                end else begin
                    count_r <= count_r;
                end
            end else begin
                sh_r    <= sh_r;
                fill_r  <= fill_r;
                count_r <= count_r;
            end
        end
    end

    // Output flag source selected by the MOORE parameter
    always_comb begin
        q_s = 1'b0;
        if (MOORE) begin
            q_s = qreg_r;
        end else begin
            q_s = match_now_s;
        end
    end

    assign Q     = q_s;
    assign count = count_r;
    assign sat   = cnt_full_s;

endmodule
